pwm_mod_mul: RTL and testbench

//  Pipelined modular multiplier mod q = 8380417 (Dilithium) computing (a*b) mod q on 23-bit residues.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_mod_csub.sv | 19 +
 rtl/pwm_mod_mul.sv | 91 +++++++++
 tb/tb_pwm_mod_mul.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the Dilithium pointwise-multiply datapath (q = 8380417).
// MODMUL_LAT is the fixed modular-multiplier latency used by the controller's write scheduling.
package pwm_pkg;

  localparam int unsigned Q_W        = 23;
  localparam int unsigned C_W        = 2 * Q_W;  // full product width
  localparam int unsigned T_W        = Q_W + 1;  // Barrett quotient estimate width
  localparam int unsigned R_W        = Q_W + 2;  // partial remainder width, holds up to 3Q-1
  localparam int unsigned BAR_K      = 46;
  localparam int unsigned MODMUL_LAT = 5;

  localparam logic [Q_W-1:0] Q     = 23'd8380417;
  localparam logic [T_W-1:0] BAR_M = 24'd8396807;
  localparam logic [R_W-1:0] Q_R   = 25'd8380417;
  localparam logic [R_W-1:0] Q2_R  = 25'd16760834;

endpackage

// File: rtl/pwm_mod_csub.sv
// Final Barrett correction: folds a partial remainder r < 3Q into [0, Q-1].
// Purely combinational; the caller registers the result.
module pwm_mod_csub
  import pwm_pkg::*;
(
  input  logic [R_W-1:0] r,
  output logic [Q_W-1:0] res
);

  always_comb begin
    res = r[Q_W-1:0];
    if (r >= Q2_R) begin
      res = Q_W'(r - Q2_R);
    end else if (r >= Q_R) begin
      res = Q_W'(r - Q_R);
    end
  end

endmodule

// File: rtl/pwm_mod_mul.sv
// Five-stage pipelined Barrett multiplier computing (a*b) mod Q, one pair per enabled cycle.
// Define PWM_MODMUL_RANGE_CHECK_EN to add the range_err flag for operands >= Q.
module pwm_mod_mul
  import pwm_pkg::*;
(
  input  logic           clk,
  input  logic           aresetn,
  input  logic           ce,
  input  logic           in_valid,
  input  logic [Q_W-1:0] mat_num_a,
  input  logic [Q_W-1:0] mat_num_b,
  output logic [Q_W-1:0] mul_result,
  output logic           out_valid
`ifdef PWM_MODMUL_RANGE_CHECK_EN
  ,
  output logic           range_err
`endif
);

  localparam int unsigned CM_W = C_W + T_W;

  logic [Q_W-1:0]  a_q, b_q;
  logic [C_W-1:0]  c2_q;
  logic [R_W-1:0]  c3_q;
  logic [T_W-1:0]  t3_q;
  logic [R_W-1:0]  r4_q;
  logic [3:0]      vld_q;  // valid for stages S1..S4, bit 0 = S1

  logic [C_W-1:0]  c_d;
  logic [CM_W-1:0] cm;
  logic [T_W-1:0]  t_d;
  logic [R_W-1:0]  r_d;
  logic [Q_W-1:0]  res_d;

  // Only the low R_W bits of c survive: c - t*Q < 3Q, so the high bits always cancel.
  always_comb begin
    c_d = C_W'(a_q) * C_W'(b_q);
    cm  = CM_W'(c2_q) * CM_W'(BAR_M);
    t_d = T_W'(cm >> BAR_K);
    r_d = c3_q - R_W'(t3_q) * Q_R;
  end

  pwm_mod_csub u_csub (
    .r   (r4_q),
    .res (res_d)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      a_q        <= '0;
      b_q        <= '0;
      c2_q       <= '0;
      c3_q       <= '0;
      t3_q       <= '0;
      r4_q       <= '0;
      vld_q      <= '0;
      mul_result <= '0;
      out_valid  <= 1'b0;
    end else if (ce) begin
      a_q        <= mat_num_a;
      b_q        <= mat_num_b;
      c2_q       <= c_d;
      c3_q       <= R_W'(c2_q);
      t3_q       <= t_d;
      r4_q       <= r_d;
      vld_q      <= {vld_q[2:0], in_valid};
      mul_result <= res_d;
      out_valid  <= vld_q[3];
    end
  end

`ifdef PWM_MODMUL_RANGE_CHECK_EN
  logic [3:0] err_q;
  logic       err_d;

  always_comb begin
    err_d = in_valid & ((mat_num_a >= Q) | (mat_num_b >= Q));
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      err_q     <= '0;
      range_err <= 1'b0;
    end else if (ce) begin
      err_q     <= {err_q[2:0], err_d};
      range_err <= err_q[3];
    end
  end
`endif

endmodule

// File: tb/tb_pwm_mod_mul.sv
// Randomized self-checking bench for pwm_mod_mul against a scoreboard of (a*b) mod q.
// Results are keyed by enabled-edge count, so ce stalls and latency are checked together.
module tb_pwm_mod_mul;

  localparam longint QM  = 64'd8380417;
  localparam int     LAT = 5;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        ce = 1'b0;
  logic        in_valid = 1'b0;
  logic [22:0] mat_num_a = '0;
  logic [22:0] mat_num_b = '0;
  logic [22:0] mul_result;
  logic        out_valid;
`ifdef PWM_MODMUL_RANGE_CHECK_EN
  logic        range_err;
`endif

  pwm_mod_mul dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .ce         (ce),
    .in_valid   (in_valid),
    .mat_num_a  (mat_num_a),
    .mat_num_b  (mat_num_b),
    .mul_result (mul_result),
    .out_valid  (out_valid)
`ifdef PWM_MODMUL_RANGE_CHECK_EN
    ,
    .range_err  (range_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    longint res;
    int     due;
    bit     legal;
  } exp_t;

  exp_t q[$];
  int   en_cnt = 0;
  bit   run = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard entry: the result must be visible after the 5th enabled edge counting the sample edge.
  always @(posedge clk) begin
    if (aresetn && ce) begin
      en_cnt <= en_cnt + 1;
      if (in_valid) begin
        q.push_back('{res: (longint'(mat_num_a) * longint'(mat_num_b)) % QM,
                      due: en_cnt + LAT,
                      legal: (longint'(mat_num_a) < QM) && (longint'(mat_num_b) < QM)});
      end
    end
  end

  always @(negedge clk) begin
    if (run && aresetn) begin
      while (q.size() > 0 && q[0].due < en_cnt) q.delete(0);
      if (q.size() > 0 && q[0].due == en_cnt) begin
        check_eq("out_valid", longint'(out_valid), 1);
        if (q[0].legal) check_eq("result", longint'(mul_result), q[0].res);
        else check_eq("bound", longint'(longint'(mul_result) < QM), 1);
`ifdef PWM_MODMUL_RANGE_CHECK_EN
        check_eq("range_err", longint'(range_err), longint'(!q[0].legal));
`endif
      end else begin
        check_eq("idle_valid", longint'(out_valid), 0);
`ifdef PWM_MODMUL_RANGE_CHECK_EN
        check_eq("idle_range_err", longint'(range_err), 0);
`endif
      end
    end
  end

  task automatic drive(input logic [22:0] a, input logic [22:0] b, input logic v, input logic en);
    mat_num_a = a;
    mat_num_b = b;
    in_valid  = v;
    ce        = en;
    @(negedge clk);
  endtask

  function automatic logic [22:0] rnd_legal();
    return 23'($urandom_range(0, 32'd8380416));
  endfunction

  function automatic logic [22:0] rnd_any();
    return 23'($urandom_range(0, 32'd8388607));
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(rnd_any(), rnd_any(), 1'b0, 1'b1);
  endtask

  initial begin
    logic [22:0] da [6];
    logic [22:0] db [6];
    da = '{23'd2, 23'd8380416, 23'd8380416, 23'd0, 23'd4194304, 23'd1};
    db = '{23'd3, 23'd8380416, 23'd2, 23'd8380416, 23'd2, 23'd1};

    // Reset state
    #12;
    check_eq("rst_result", longint'(mul_result), 0);
    check_eq("rst_valid", longint'(out_valid), 0);
    @(negedge clk);
    aresetn = 1'b1;
    run = 1'b1;
    idle(3);

    // Directed corner pairs, single pulse first then back-to-back
    drive(da[0], db[0], 1'b1, 1'b1);
    idle(7);
    for (int i = 1; i < 6; i++) drive(da[i], db[i], 1'b1, 1'b1);
    idle(7);

    // Back-to-back random stream of legal pairs
    for (int i = 0; i < 1000; i++) drive(rnd_legal(), rnd_legal(), 1'b1, 1'b1);
    idle(7);

    // ce low for 3 cycles mid-stream, inputs toggling and ignored
    for (int i = 0; i < 20; i++) begin
      if (i >= 10 && i < 13) drive(rnd_any(), rnd_any(), 1'b1, 1'b0);
      else drive(rnd_legal(), rnd_legal(), 1'b1, 1'b1);
    end
    idle(7);

    // Random ce and in_valid
    for (int i = 0; i < 300; i++)
      drive(rnd_legal(), rnd_legal(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    idle(7);

    // Asynchronous reset with 3 pairs in flight
    for (int i = 0; i < 3; i++) drive(rnd_legal(), rnd_legal(), 1'b1, 1'b1);
    in_valid = 1'b0;
    #3;
    aresetn = 1'b0;
    #1;
    check_eq("midrst_result", longint'(mul_result), 0);
    check_eq("midrst_valid", longint'(out_valid), 0);
`ifdef PWM_MODMUL_RANGE_CHECK_EN
    check_eq("midrst_range_err", longint'(range_err), 0);
`endif
    q.delete();
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    idle(8);
    for (int i = 0; i < 10; i++) drive(rnd_legal(), rnd_legal(), 1'b1, 1'b1);
    idle(7);

    // Out-of-range operands mixed with legal ones
    drive(23'd8380417, 23'd1, 1'b1, 1'b1);
    drive(23'd1, 23'd2, 1'b1, 1'b1);
    drive(23'd8388607, 23'd8388607, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) drive(rnd_any(), rnd_any(), 1'b1, 1'b1);
    idle(8);

    check_eq("drained", longint'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
